conv_frame_scheduler: RTL and testbench

- Sequences a single-window convolution engine across a whole IMG_W x IMG_H input frame.
- For each valid output pixel it issues a start pulse and the window base address, then waits for the engine's done.
- It captures the result and writes it to the output SRAM under a ready handshake.
- It sits between the top-level NPU control and the convolution engine / result buffer, and includes a watchdog for a hung engine.

---
 rtl/conv_frame_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_conv_frame_scheduler.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_scheduler.sv
// ---------------------------------------------------------------------------
// conv_frame_scheduler
//
// Walks a single-window convolution engine across every valid output position
// of an IMG_W x IMG_H frame. For each position it pulses the engine with the
// window's top-left address, waits (under a watchdog) for the engine result,
// then writes that result to the output SRAM in raster order.
//
// Ports:
//   i_clk / i_rst_n      clock (rising edge), asynchronous active-low reset
//   i_start              start a frame (only honoured in IDLE)
//   o_busy               registered, high whenever the FSM is not in IDLE
//   o_done               one-cycle pulse at frame end (normal or aborted)
//   o_error              sticky watchdog flag, cleared by the next accepted start
//   o_conv_start         one-cycle start pulse to the engine
//   o_first_pixel        qualifies o_conv_start for window (0,0): kernel reload
//   o_win_base_addr      row*IMG_W+col of the window's top-left pixel
//   i_conv_done          engine result valid (single-cycle pulse)
//   i_conv_result        engine result
//   o_wr_en / o_wr_addr / o_wr_data / i_wr_ready
//                        output SRAM write port
//   o_dbg_state          current FSM state, for observation only
//
// Handshake: the output write is a valid/ready transfer. o_wr_en is the valid;
// once raised, o_wr_addr and o_wr_data are held stable until a cycle where
// i_wr_ready is also high, and that cycle (and only that cycle) is the transfer.
// ---------------------------------------------------------------------------
module conv_frame_scheduler #(
    parameter int IMG_W       = 8,
    parameter int IMG_H       = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 6,
    parameter int TIMEOUT     = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic                  o_conv_start,
    output logic                  o_first_pixel,
    output logic [ADDR_WIDTH-1:0] o_win_base_addr,
    input  logic                  i_conv_done,
    input  logic [DATA_WIDTH-1:0] i_conv_result,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    input  logic                  i_wr_ready,
    output logic [2:0]            o_dbg_state
);

    localparam int OUT_W = IMG_W - KERNEL_SIZE + 1;
    localparam int OUT_H = IMG_H - KERNEL_SIZE + 1;
    localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_WRITE  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [RW-1:0]         r_row;
    logic [CW-1:0]         r_col;
    logic [ADDR_WIDTH-1:0] r_out_idx;
    logic [TW-1:0]         r_wdog;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_error;
    logic                  r_busy;

    logic                  w_last_col;
    logic                  w_last_row;
    logic                  w_last_pix;
    logic                  w_xfer;
    logic                  w_timeout;
    logic [ADDR_WIDTH-1:0] w_base;

    assign w_last_col = (r_col == CW'(OUT_W - 1));
    assign w_last_row = (r_row == RW'(OUT_H - 1));
    assign w_last_pix = w_last_col && w_last_row;
    assign w_xfer     = (r_state == S_WRITE) && i_wr_ready;
    // Abort on the WAIT cycle whose increment brings the counter to TIMEOUT-1,
    // so FINISH follows ISSUE by exactly TIMEOUT cycles.
    assign w_timeout  = ((r_wdog + TW'(1)) == TW'(TIMEOUT - 1));
    assign w_base     = ADDR_WIDTH'(r_row) * ADDR_WIDTH'(IMG_W) + ADDR_WIDTH'(r_col);

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_next = S_ISSUE;
            S_ISSUE:  w_next = S_WAIT;
            S_WAIT: begin
                // A result arriving on the timeout cycle still wins.
                if (i_conv_done)    w_next = S_WRITE;
                else if (w_timeout) w_next = S_FINISH;
            end
            S_WRITE: begin
                if (w_xfer) w_next = w_last_pix ? S_FINISH : S_ISSUE;
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
        end
    end

    // Datapath: window position, output index, watchdog, captured result
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row     <= '0;
            r_col     <= '0;
            r_out_idx <= '0;
            r_wdog    <= '0;
            r_data    <= '0;
            r_error   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_row     <= '0;
                        r_col     <= '0;
                        r_out_idx <= '0;
                        r_error   <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    r_wdog <= '0;
                end
                S_WAIT: begin
                    r_wdog <= r_wdog + TW'(1);
                    if (i_conv_done)    r_data  <= i_conv_result;
                    else if (w_timeout) r_error <= 1'b1;
                end
                S_WRITE: begin
                    if (w_xfer) begin
                        r_out_idx <= r_out_idx + ADDR_WIDTH'(1);
                        if (!w_last_pix) begin
                            if (w_last_col) begin
                                r_col <= '0;
                                r_row <= r_row + RW'(1);
                            end else begin
                                r_col <= r_col + CW'(1);
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs are decoded from registered state, so an asynchronous reset
    // forces them all low immediately.
    assign o_busy          = r_busy;
    assign o_done          = (r_state == S_FINISH);
    assign o_error         = r_error;
    assign o_conv_start    = (r_state == S_ISSUE);
    assign o_first_pixel   = (r_state == S_ISSUE) && (r_row == '0) && (r_col == '0);
    assign o_win_base_addr = (r_state == S_ISSUE) ? w_base : '0;
    assign o_wr_en         = (r_state == S_WRITE);
    assign o_wr_addr       = (r_state == S_WRITE) ? r_out_idx : '0;
    assign o_wr_data       = (r_state == S_WRITE) ? r_data : '0;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_conv_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_conv_frame_scheduler
//
// Directed bench for conv_frame_scheduler on a 5x4 frame with a 3x3 kernel
// (3x2 output positions, window bases 0,1,2,5,6,7) and TIMEOUT=8.
// Inputs change 1 time unit after the rising edge; a monitor samples outputs
// on the falling edge and logs starts, writes and done pulses into queues that
// the scenario tasks compare against hand-derived expectations.
// ---------------------------------------------------------------------------
module tb_conv_frame_scheduler;

    localparam int IMG_W = 5;
    localparam int IMG_H = 4;
    localparam int KS    = 3;
    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int TMO   = 8;

    logic          clk;
    logic          rst_n;
    logic          i_start;
    logic          o_busy;
    logic          o_done;
    logic          o_error;
    logic          o_conv_start;
    logic          o_first_pixel;
    logic [AW-1:0] o_win_base_addr;
    logic          i_conv_done;
    logic [DW-1:0] i_conv_result;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic [DW-1:0] o_wr_data;
    logic          i_wr_ready;
    logic [2:0]    o_dbg_state;

    int total = 0;
    int bad   = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got time=%0t required finish", $time);
        $fatal(1, "global timeout");
    end

    conv_frame_scheduler #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .KERNEL_SIZE(KS),
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TMO)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (i_start),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_error         (o_error),
        .o_conv_start    (o_conv_start),
        .o_first_pixel   (o_first_pixel),
        .o_win_base_addr (o_win_base_addr),
        .i_conv_done     (i_conv_done),
        .i_conv_result   (i_conv_result),
        .o_wr_en         (o_wr_en),
        .o_wr_addr       (o_wr_addr),
        .o_wr_data       (o_wr_data),
        .i_wr_ready      (i_wr_ready),
        .o_dbg_state     (o_dbg_state)
    );

    // ---------------- engine model / manual engine drive ----------------
    logic          eng_en = 1'b0;
    logic          eng_done = 1'b0;
    logic [DW-1:0] eng_res = '0;
    logic [AW-1:0] eng_base = '0;
    int            eng_cnt = 0;
    logic          man_done;
    logic [DW-1:0] man_res;

    // Engine answers 2 cycles after its start pulse with result = base address.
    always @(posedge clk) begin
        #1;
        eng_done = 1'b0;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                eng_done = 1'b1;
                eng_res  = DW'(eng_base);
            end
        end
        if (o_conv_start) begin
            eng_cnt  = 2;
            eng_base = o_win_base_addr;
        end
    end

    assign i_conv_done   = eng_en ? eng_done : man_done;
    assign i_conv_result = eng_en ? eng_res  : man_res;

    // ---------------- monitor ----------------
    logic [AW-1:0] st_base[$];
    logic          st_first[$];
    int            st_cyc[$];
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];
    int            done_cnt = 0;
    int            done_cyc = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_conv_start) begin
                st_base.push_back(o_win_base_addr);
                st_first.push_back(o_first_pixel);
                st_cyc.push_back(cyc);
            end
            if (o_wr_en && i_wr_ready) begin
                wa_q.push_back(o_wr_addr);
                wd_q.push_back(o_wr_data);
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Expected write data for the normal engine: the window bases in raster order.
    logic [DW-1:0] exp_q[$];

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(posedge clk); #1;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_frame_done(input int d0, output int n);
        n = 0;
        while (done_cnt == d0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; i_start = 1'b0; i_wr_ready = 1'b0;
        man_done = 1'b0; man_res = '0; eng_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({o_busy, o_done, o_error, o_conv_start, o_first_pixel, o_wr_en} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b required 000000",
                     {o_busy, o_done, o_error, o_conv_start, o_first_pixel, o_wr_en});
        end
        total++;
        if ({o_win_base_addr, o_wr_addr, o_wr_data} !== '0) begin
            bad++;
            $display("FAIL reset_buses: got base=%0d wa=%0d wd=%0d required 0",
                     o_win_base_addr, o_wr_addr, o_wr_data);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (o_dbg_state !== 3'd0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got state=%0d busy=%b required 0/0", o_dbg_state, o_busy);
        end
    endtask

    task automatic test_normal();
        int s0, w0, d0, n;
        s0 = st_base.size(); w0 = wa_q.size(); d0 = done_cnt;
        eng_en = 1'b1; i_wr_ready = 1'b1;
        pulse_start();
        wait_frame_done(d0, n);
        total++;
        if (done_cnt == d0) begin bad++; $display("FAIL normal_wait: no done after %0d cycles", n); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (st_base.size() - s0 !== 6) begin
            bad++; $display("FAIL normal_starts: got %0d required 6", st_base.size() - s0);
        end
        for (int i = 0; i < 6 && s0 + i < st_base.size(); i++) begin
            total++;
            if (st_base[s0+i] !== AW'(exp_q[i])) begin
                bad++; $display("FAIL normal_base[%0d]: got %0d required %0d", i, st_base[s0+i], exp_q[i]);
            end
            total++;
            if (st_first[s0+i] !== (i == 0)) begin
                bad++; $display("FAIL normal_first[%0d]: got %b required %b", i, st_first[s0+i], i == 0);
            end
        end
        total++;
        if (wa_q.size() - w0 !== 6) begin
            bad++; $display("FAIL normal_writes: got %0d required 6", wa_q.size() - w0);
        end
        for (int i = 0; i < 6 && w0 + i < wa_q.size(); i++) begin
            total++;
            if (wa_q[w0+i] !== AW'(i) || wd_q[w0+i] !== exp_q[i]) begin
                bad++; $display("FAIL normal_wr[%0d]: got addr=%0d data=%0d required addr=%0d data=%0d",
                                i, wa_q[w0+i], wd_q[w0+i], i, exp_q[i]);
            end
        end
        total++;
        if (done_cnt - d0 !== 1 || o_busy !== 1'b0 || o_error !== 1'b0) begin
            bad++; $display("FAIL normal_end: got done=%0d busy=%b err=%b required 1/0/0",
                            done_cnt - d0, o_busy, o_error);
        end
    endtask

    task automatic test_backpressure();
        int s0, w0, d0, n, held, stall_starts;
        s0 = st_base.size(); w0 = wa_q.size(); d0 = done_cnt;
        held = 0; stall_starts = 0;
        eng_en = 1'b1; i_wr_ready = 1'b1;
        pulse_start();
        n = 0;
        while (done_cnt == d0 && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (held == 0 && o_wr_en && o_wr_addr == AW'(2)) begin
                held = 1;
                i_wr_ready = 1'b0;
                stall_starts = st_base.size();
                total++;
                if (o_wr_data !== 8'd2) begin
                    bad++; $display("FAIL bp_data_first: got %0d required 2", o_wr_data);
                end
            end else if (held > 0 && held < 4) begin
                held++;
                total++;
                if (o_wr_en !== 1'b1 || o_wr_addr !== AW'(2) || o_wr_data !== 8'd2) begin
                    bad++; $display("FAIL bp_hold[%0d]: got en=%b addr=%0d data=%0d required 1/2/2",
                                    held, o_wr_en, o_wr_addr, o_wr_data);
                end
                total++;
                if (st_base.size() !== stall_starts || o_conv_start !== 1'b0) begin
                    bad++; $display("FAIL bp_no_start[%0d]: got starts=%0d required %0d",
                                    held, st_base.size() - s0, stall_starts - s0);
                end
            end else begin
                i_wr_ready = 1'b1;
            end
        end
        i_wr_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (held !== 4 || done_cnt == d0) begin
            bad++; $display("FAIL bp_stall: got held=%0d done=%0d required 4/1", held, done_cnt - d0);
        end
        total++;
        if (wa_q.size() - w0 !== 6 || st_base.size() - s0 !== 6) begin
            bad++; $display("FAIL bp_counts: got writes=%0d starts=%0d required 6/6",
                            wa_q.size() - w0, st_base.size() - s0);
        end
        for (int i = 0; i < 6 && w0 + i < wa_q.size(); i++) begin
            total++;
            if (wa_q[w0+i] !== AW'(i) || wd_q[w0+i] !== exp_q[i]) begin
                bad++; $display("FAIL bp_wr[%0d]: got addr=%0d data=%0d required addr=%0d data=%0d",
                                i, wa_q[w0+i], wd_q[w0+i], i, exp_q[i]);
            end
        end
    endtask

    task automatic test_watchdog();
        int s0, w0, d0, n;
        s0 = st_base.size(); w0 = wa_q.size(); d0 = done_cnt;
        eng_en = 1'b0; man_done = 1'b0; i_wr_ready = 1'b1;
        pulse_start();
        wait_frame_done(d0, n);
        @(negedge clk);
        total++;
        if (st_base.size() - s0 !== 1 || done_cnt - d0 !== 1) begin
            bad++; $display("FAIL wd_counts: got starts=%0d done=%0d required 1/1",
                            st_base.size() - s0, done_cnt - d0);
        end
        total++;
        if (st_base.size() > s0 && done_cyc - st_cyc[s0] !== TMO) begin
            bad++; $display("FAIL wd_latency: got %0d required %0d", done_cyc - st_cyc[s0], TMO);
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        total++;
        if (o_error !== 1'b1 || o_busy !== 1'b0 || done_cnt - d0 !== 1 || wa_q.size() !== w0) begin
            bad++; $display("FAIL wd_sticky: got err=%b busy=%b done=%0d writes=%0d required 1/0/1/0",
                            o_error, o_busy, done_cnt - d0, wa_q.size() - w0);
        end
        // Recovery frame with a responsive engine.
        s0 = st_base.size(); w0 = wa_q.size(); d0 = done_cnt;
        eng_en = 1'b1;
        pulse_start();
        total++;
        if (o_error !== 1'b0 || o_conv_start !== 1'b1) begin
            bad++; $display("FAIL wd_clear: got err=%b start=%b required 0/1", o_error, o_conv_start);
        end
        wait_frame_done(d0, n);
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (wa_q.size() - w0 !== 6 || o_error !== 1'b0 || done_cnt - d0 !== 1) begin
            bad++; $display("FAIL wd_recover: got writes=%0d err=%b done=%0d required 6/0/1",
                            wa_q.size() - w0, o_error, done_cnt - d0);
        end
        for (int i = 0; i < 6 && w0 + i < wa_q.size(); i++) begin
            total++;
            if (wd_q[w0+i] !== exp_q[i]) begin
                bad++; $display("FAIL wd_recover_wr[%0d]: got %0d required %0d", i, wd_q[w0+i], exp_q[i]);
            end
        end
    endtask

    task automatic test_spurious();
        int s0, w0, d0, n;
        int dly[6];
        logic [AW-1:0] base;
        dly = '{1, 2, TMO - 1, 1, 3, 1};
        s0 = st_base.size(); w0 = wa_q.size(); d0 = done_cnt;
        eng_en = 1'b0; man_done = 1'b0; i_wr_ready = 1'b1;
        pulse_start();
        for (int p = 0; p < 6; p++) begin
            n = 0;
            while (!o_conv_start && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            total++;
            if (o_conv_start !== 1'b1) begin
                bad++; $display("FAIL spur_issue[%0d]: got start=%b required 1", p, o_conv_start);
            end
            base = o_win_base_addr;
            // Walk the WAIT cycles; pixel 1 sees a stray i_start in its first one.
            for (int d = 1; d <= dly[p]; d++) begin
                @(posedge clk); #1;
                i_start = (p == 1 && d == 1);
            end
            man_done = 1'b1;
            man_res  = DW'(base) + 8'h40;
            @(posedge clk); #1;
            i_start = 1'b0;
            total++;
            if (o_wr_en !== 1'b1 || o_error !== 1'b0) begin
                bad++; $display("FAIL spur_write[%0d]: got en=%b err=%b required 1/0", p, o_wr_en, o_error);
            end
            // Stray done during WRITE must not overwrite the captured result.
            man_res = 8'hEE;
            @(posedge clk); #1;
            man_done = 1'b0;
        end
        wait_frame_done(d0, n);
        // Stray done while IDLE.
        repeat (2) @(posedge clk);
        #1;
        man_done = 1'b1; man_res = 8'h11;
        @(posedge clk); #1;
        man_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (st_base.size() - s0 !== 6 || wa_q.size() - w0 !== 6 || done_cnt - d0 !== 1) begin
            bad++; $display("FAIL spur_counts: got starts=%0d writes=%0d done=%0d required 6/6/1",
                            st_base.size() - s0, wa_q.size() - w0, done_cnt - d0);
        end
        total++;
        if (o_busy !== 1'b0 || o_error !== 1'b0) begin
            bad++; $display("FAIL spur_idle: got busy=%b err=%b required 0/0", o_busy, o_error);
        end
        for (int i = 0; i < 6 && w0 + i < wa_q.size(); i++) begin
            total++;
            if (wa_q[w0+i] !== AW'(i) || wd_q[w0+i] !== exp_q[i] + 8'h40) begin
                bad++; $display("FAIL spur_wr[%0d]: got addr=%0d data=%0d required addr=%0d data=%0d",
                                i, wa_q[w0+i], wd_q[w0+i], i, exp_q[i] + 8'h40);
            end
        end
    endtask

    task automatic test_reset_mid();
        int s0, w0, d0, n;
        s0 = st_base.size(); d0 = done_cnt;
        eng_en = 1'b1; i_wr_ready = 1'b1;
        pulse_start();
        n = 0;
        while (st_base.size() - s0 < 4 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        // Now in the first cycle of the 4th WAIT.
        total++;
        if (o_dbg_state !== 3'd2 || st_base.size() - s0 !== 4) begin
            bad++; $display("FAIL mid_pre: got state=%0d starts=%0d required 2/4",
                            o_dbg_state, st_base.size() - s0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({o_busy, o_done, o_error, o_conv_start, o_first_pixel, o_wr_en,
             o_win_base_addr, o_wr_addr, o_wr_data} !== '0 || o_dbg_state !== 3'd0) begin
            bad++; $display("FAIL mid_async: got busy=%b en=%b state=%0d required all 0",
                            o_busy, o_wr_en, o_dbg_state);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        total++;
        if (done_cnt !== d0 || o_busy !== 1'b0) begin
            bad++; $display("FAIL mid_no_done: got done=%0d busy=%b required 0/0", done_cnt - d0, o_busy);
        end
        s0 = st_base.size(); w0 = wa_q.size(); d0 = done_cnt;
        pulse_start();
        wait_frame_done(d0, n);
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (st_base.size() <= s0 || st_base[s0] !== AW'(0) || st_first[s0] !== 1'b1) begin
            bad++; $display("FAIL mid_restart: got starts=%0d required first base 0 with first_pixel",
                            st_base.size() - s0);
        end
        total++;
        if (wa_q.size() - w0 !== 6 || done_cnt - d0 !== 1) begin
            bad++; $display("FAIL mid_frame: got writes=%0d done=%0d required 6/1",
                            wa_q.size() - w0, done_cnt - d0);
        end
        for (int i = 0; i < 6 && w0 + i < wa_q.size(); i++) begin
            total++;
            if (wa_q[w0+i] !== AW'(i) || wd_q[w0+i] !== exp_q[i]) begin
                bad++; $display("FAIL mid_wr[%0d]: got addr=%0d data=%0d required addr=%0d data=%0d",
                                i, wa_q[w0+i], wd_q[w0+i], i, exp_q[i]);
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        for (int r = 0; r < IMG_H - KS + 1; r++)
            for (int c = 0; c < IMG_W - KS + 1; c++)
                exp_q.push_back(DW'(r * IMG_W + c));
        test_reset();
        test_normal();
        test_backpressure();
        test_watchdog();
        test_spurious();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
